dot_eater: RTL and testbench

- Owns dot-consumption state for the maze: the write side of the eaten-dot bitmap that the dot renderer reads.
- On each frame tick, scans all 32 dots sequentially, one per clock, and tests each against Pac-Man's bounding box.
- Marks each colliding dot as eaten, updates score and remaining count, and flags level clear.
- Sits between the Pac-Man motion logic and the dot renderer/score display.

---
 rtl/dot_eater.sv | 147 ++++++++++++++
 tb/tb_dot_eater.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_eater.sv
// rtl/dot_eater.sv - eaten-dot bitmap, remaining count, score and level-clear for the 32 maze dots
// A frame tick starts a one-dot-per-clock scan against a snapshot of Pac-Man's box.
module dot_eater #(
  parameter int X0     = 40,
  parameter int Y0     = 40,
  parameter int XSTEP  = 72,
  parameter int YSTEP  = 120,
  parameter int DOT_SZ = 6,
  parameter int PTS    = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        level_restart,
  input  logic [9:0]  pX,
  input  logic [9:0]  pY,
  input  logic [9:0]  pS,
  output logic [31:0] dots_eaten,
  output logic [5:0]  dots_remaining,
  output logic [15:0] score,
  output logic        eat_pulse,
  output logic        scan_done,
  output logic        all_clear,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [9:0]  px_q, px_d, py_q, py_d, ps_q, ps_d;
  logic [31:0] eaten_q, eaten_d;
  logic [5:0]  remaining_q, remaining_d;
  logic [15:0] score_q, score_d;
  logic        eat_q, eat_d;
  logic        clear_q, clear_d;

  logic [10:0] dot_x, dot_y, box_r, box_b;
  logic [16:0] score_sum;
  logic [15:0] score_sat;
  logic        hit, new_eat;

  assign dot_x = 11'(X0) + 11'(idx_q[2:0]) * 11'(XSTEP);
  assign dot_y = 11'(Y0) + 11'(idx_q[4:3]) * 11'(YSTEP);

  // 11 bits hold pX+pS-1 without wrap; pS==0 is excluded before it matters
  assign box_r = {1'b0, px_q} + {1'b0, ps_q} - 11'd1;
  assign box_b = {1'b0, py_q} + {1'b0, ps_q} - 11'd1;

  assign hit = (ps_q != 10'd0)
            && (dot_x + 11'(DOT_SZ - 1) >= {1'b0, px_q}) && (dot_x <= box_r)
            && (dot_y + 11'(DOT_SZ - 1) >= {1'b0, py_q}) && (dot_y <= box_b);

  assign new_eat = (state_q == S_SCAN) && hit && !eaten_q[idx_q];

  assign score_sum = {1'b0, score_q} + 17'(PTS);
  assign score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (frame_tick) state_d = S_SCAN;
      S_SCAN:  if (idx_q == 5'd31) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (level_restart) state_d = S_IDLE;
  end

  always_comb begin
    idx_d       = idx_q;
    px_d        = px_q;
    py_d        = py_q;
    ps_d        = ps_q;
    eaten_d     = eaten_q;
    remaining_d = remaining_q;
    score_d     = score_q;
    eat_d       = 1'b0;
    clear_d     = 1'b0;
    if (level_restart) begin
      idx_d       = 5'd0;
      eaten_d     = 32'd0;
      remaining_d = 6'd32;
    end else begin
      if (state_q == S_IDLE && frame_tick) begin
        idx_d = 5'd0;
        px_d  = pX;
        py_d  = pY;
        ps_d  = pS;
      end
      if (state_q == S_SCAN) begin
        idx_d = idx_q + 5'd1;
        if (new_eat) begin
          eaten_d[idx_q] = 1'b1;
          remaining_d    = remaining_q - 6'd1;
          score_d        = score_sat;
          eat_d          = 1'b1;
          clear_d        = (remaining_q == 6'd1);
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      idx_q       <= 5'd0;
      px_q        <= 10'd0;
      py_q        <= 10'd0;
      ps_q        <= 10'd0;
      eaten_q     <= 32'd0;
      remaining_q <= 6'd32;
      score_q     <= 16'd0;
      eat_q       <= 1'b0;
      clear_q     <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      px_q        <= px_d;
      py_q        <= py_d;
      ps_q        <= ps_d;
      eaten_q     <= eaten_d;
      remaining_q <= remaining_d;
      score_q     <= score_d;
      eat_q       <= eat_d;
      clear_q     <= clear_d;
    end
  end

  always_comb begin
    busy      = (state_q == S_SCAN);
    scan_done = (state_q == S_DONE);
  end

  assign dots_eaten     = eaten_q;
  assign dots_remaining = remaining_q;
  assign score          = score_q;
  assign eat_pulse      = eat_q;
  assign all_clear      = clear_q;

endmodule

// File: tb/tb_dot_eater.sv
// tb/tb_dot_eater.sv - scoreboard bench for dot_eater
// Expected pulse cycles are queued at each frame tick and retired as the DUT pulses.
module tb_dot_eater;

  logic        Clk = 1'b0;
  logic        Reset, frame_tick, level_restart;
  logic [9:0]  pX, pY, pS;
  logic [31:0] dots_eaten;
  logic [5:0]  dots_remaining;
  logic [15:0] score;
  logic        eat_pulse, scan_done, all_clear, busy;

  dot_eater dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .level_restart(level_restart),
    .pX(pX), .pY(pY), .pS(pS),
    .dots_eaten(dots_eaten), .dots_remaining(dots_remaining), .score(score),
    .eat_pulse(eat_pulse), .scan_done(scan_done), .all_clear(all_clear), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int clr_cnt = 0;
  int done_cnt = 0;

  int eat_q[$];
  int clr_q[$];
  int done_q[$];

  logic [31:0] m_eaten;
  int          m_rem;
  int          m_score;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Retire expected pulses; anything overdue counts as missing
  always @(negedge Clk) begin
    if (eat_q.size() > 0 && eat_q[0] < cyc) begin
      chk("eat_missing", 32'(eat_q[0]), 32'(cyc));
      void'(eat_q.pop_front());
    end
    if (clr_q.size() > 0 && clr_q[0] < cyc) begin
      chk("clear_missing", 32'(clr_q[0]), 32'(cyc));
      void'(clr_q.pop_front());
    end
    if (done_q.size() > 0 && done_q[0] < cyc) begin
      chk("done_missing", 32'(done_q[0]), 32'(cyc));
      void'(done_q.pop_front());
    end
    if (eat_pulse) begin
      chk("eat_cycle", 32'(cyc), (eat_q.size() > 0) ? 32'(eat_q[0]) : 32'hFFFF_FFFF);
      if (eat_q.size() > 0 && eat_q[0] == cyc) void'(eat_q.pop_front());
    end
    if (all_clear) begin
      clr_cnt++;
      chk("clear_cycle", 32'(cyc), (clr_q.size() > 0) ? 32'(clr_q[0]) : 32'hFFFF_FFFF);
      if (clr_q.size() > 0 && clr_q[0] == cyc) void'(clr_q.pop_front());
    end
    if (scan_done) begin
      done_cnt++;
      chk("done_cycle", 32'(cyc), (done_q.size() > 0) ? 32'(done_q[0]) : 32'hFFFF_FFFF);
      if (done_q.size() > 0 && done_q[0] == cyc) void'(done_q.pop_front());
    end
  end

  function automatic bit m_hit(input int i, input int px, input int py, input int ps);
    int dx, dy;
    dx = 40 + (i % 8) * 72;
    dy = 40 + (i / 8) * 120;
    return (ps != 0) && (dx + 5 >= px) && (dx <= px + ps - 1)
        && (dy + 5 >= py) && (dy <= py + ps - 1);
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic go_to(input int c);
    int n = 0;
    while (cyc < c && n < 1000) begin
      step();
      n++;
    end
  endtask

  task automatic model_clear();
    m_eaten = 32'd0;
    m_rem   = 32;
  endtask

  // Drop everything the DUT can no longer produce after an abort during cycle r
  task automatic abort_at(input int r);
    int kept[$];
    kept = eat_q.find(x) with (x <= r);
    m_score = m_score - 10 * (eat_q.size() - kept.size());
    eat_q  = kept;
    clr_q  = clr_q.find(x) with (x <= r);
    done_q = done_q.find(x) with (x <= r);
    model_clear();
  endtask

  task automatic tick(input int px, input int py, input int ps, output int t);
    step();
    pX = 10'(px);
    pY = 10'(py);
    pS = 10'(ps);
    frame_tick = 1'b1;
    t = cyc;
    for (int i = 0; i < 32; i++) begin
      if (m_hit(i, px, py, ps) && !m_eaten[i]) begin
        m_eaten[i] = 1'b1;
        m_rem--;
        m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
        eat_q.push_back(t + 2 + i);
        if (m_rem == 0) clr_q.push_back(t + 2 + i);
      end
    end
    done_q.push_back(t + 33);
    step();
    frame_tick = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (done_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("scan_timeout", 32'(n), 32'd0);
    step();
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_eaten"}, dots_eaten, m_eaten);
    chk({tag, "_rem"}, 32'(dots_remaining), 32'(m_rem));
    chk({tag, "_score"}, 32'(score), 32'(m_score));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic restart();
    step();
    level_restart = 1'b1;
    abort_at(cyc);
    step();
    level_restart = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    eat_q = {};
    clr_q = {};
    done_q = {};
    model_clear();
    m_score = 0;
    step();
    step();
    Reset = 1'b0;
  endtask

  int t;

  initial begin
    frame_tick = 1'b0;
    level_restart = 1'b0;
    pX = '0;
    pY = '0;
    pS = '0;
    do_reset();
    chk("rst_eaten", dots_eaten, 32'd0);
    chk("rst_rem", 32'(dots_remaining), 32'd32);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_pulses", {28'd0, eat_pulse, scan_done, all_clear, busy}, 32'd0);

    tick(300, 300, 16, t);
    chk("scan_busy", 32'(busy), 32'd1);
    wait_idle();
    chk_model("nohit");
    chk("nohit_rem_const", 32'(dots_remaining), 32'd32);

    tick(100, 150, 16, t);
    wait_idle();
    chk_model("dot9");
    chk("dot9_bitmap_const", dots_eaten, 32'h0000_0200);
    chk("dot9_score_const", 32'(score), 32'd10);
    tick(100, 150, 16, t);
    wait_idle();
    chk_model("dot9_again");

    restart();
    chk_model("restart1");
    tick(117, 150, 16, t);
    wait_idle();
    chk_model("edge117");
    restart();
    tick(118, 150, 16, t);
    wait_idle();
    chk_model("edge118");
    restart();
    tick(112, 160, 0, t);
    wait_idle();
    chk_model("size0");

    do_reset();
    clr_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      tick(40 + (i % 8) * 72, 40 + (i / 8) * 120, 6, t);
      wait_idle();
    end
    chk_model("all32");
    chk("all32_score_const", 32'(score), 32'd320);
    chk("all32_rem_const", 32'(dots_remaining), 32'd0);
    chk("all32_clear_count", 32'(clr_cnt), 32'd1);

    restart();
    tick(328, 280, 6, t);
    go_to(t + 5);
    level_restart = 1'b1;
    abort_at(cyc);
    step();
    level_restart = 1'b0;
    chk_model("abort");
    chk("abort_score_const", 32'(score), 32'd320);

    done_cnt = 0;
    tick(328, 280, 6, t);
    go_to(t + 10);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    wait_idle();
    repeat (40) step();
    chk_model("ignored_tick");
    chk("ignored_tick_done_count", 32'(done_cnt), 32'd1);
    chk("ignored_tick_score_const", 32'(score), 32'd330);

    tick(112, 400, 6, t);
    go_to(t + 20);
    Reset = 1'b1;
    abort_at(cyc);
    m_score = 0;
    step();
    Reset = 1'b0;
    chk_model("midreset");
    chk("midreset_pulses", {28'd0, eat_pulse, scan_done, all_clear, busy}, 32'd0);
    repeat (40) step();
    chk_model("midreset_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
